weight_buffer_banked: RTL and testbench
=======================================

Name: weight_buffer_banked

Overview:
- Parametrised, writable successor to the fixed ROM-style weight buffers feeding the LSTM MAC lanes.
- BANKS single-port banks, each word packing LANES weights of DATA_WIDTH bits.
- Host loads weights through a write port; an internal sequencer streams a run of LEN consecutive rows from all banks in lock-step.
- Per-bank address offset, modulo wrap, hold/stall, and a done pulse.

Parameters:
- DATA_WIDTH, 18, bits per weight
- LANES, 16, weights per bank word
- BANKS, 2, number of parallel banks/output channels
- DEPTH, 64, words per bank
- ADDR_WIDTH, 6, clog2(DEPTH)
- BANK_STRIDE, 1, address offset added per bank index (bank b uses b*BANK_STRIDE)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  load one word
- wr_ready  out  1  high only in IDLE
- wr_bank  in  clog2(BANKS) (min 1)  target bank
- wr_addr  in  ADDR_WIDTH  target word
- wr_data  in  LANES*DATA_WIDTH  packed word, lane 0 in LSBs
- start  in  1  begin a streaming run (sampled in IDLE only)
- base_index  in  ADDR_WIDTH  first row, latched on start
- len  in  ADDR_WIDTH+1  rows to stream, 0 allowed
- hold  in  1  freeze sequencer and output pipeline
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after last valid output
- q  out  BANKS*LANES*DATA_WIDTH  bank b occupies slice b*LANES*DATA_WIDTH upward
- q_valid  out  1  q holds a streamed row

Behaviour:
- Reset: state IDLE; counters 0; q=0, q_valid=0, done=0, busy=0, wr_ready=0 during the reset cycle, then 1. RAM contents are not cleared.
- Write: accepted when wr_valid && wr_ready; bank wr_bank at wr_addr is written at the next edge. Out-of-range wr_bank is ignored. Writes are ignored outside IDLE.
- Sequencer FSM:
  - IDLE --start, len!=0--> RUN. Latch base_index and len; idx=0.
  - IDLE --start, len==0--> IDLE, with done pulsed the next cycle.
  - RUN issues idx each non-hold cycle. After issuing idx==len-1 --> DRAIN.
  - DRAIN waits until the last row has left the pipeline, then --> IDLE with done=1 for one cycle.
  - start while busy is ignored.
- Address: addr_b = (base + idx + b*BANK_STRIDE) mod DEPTH; wraps at DEPTH, with explicit modulo when DEPTH is not a power of two.
- Latency: 2 cycles from issue to q/q_valid (stage 1 registers addr, stage 2 registers RAM output). Row idx=k appears on q exactly 2 non-hold cycles after issue.
- hold:
  - All pipeline registers, idx and state keep their values; q and q_valid are held.
  - No new issue; done is deferred while hold is high.
  - Bank RAM read is gated by stage enable so q stays stable.
- q_valid: high for exactly len non-hold cycles per run; deasserted otherwise. q keeps its last value when q_valid=0.
- Reset mid-run: immediate return to IDLE. q_valid=0 and done=0 the next cycle, with no done pulse for the aborted run.

Optional Feature:
- Macro WEIGHT_BUFFER_PARITY_EN.
- Defined:
  - Each bank stores one extra even-parity bit per lane, computed on write.
  - On read, parity is recomputed in stage 2.
  - Output parity_err (1 bit, registered, aligned with q_valid) is high if any lane of any bank mismatches; cleared on reset.
  - RAM width per bank is LANES*(DATA_WIDTH+1).
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Package weight_buffer_pkg: state enum (IDLE, RUN, DRAIN), function computing the per-bank address with modulo, word-width constants.
- Sub-module weight_bank_ram: single-port RAM, width LANES*DATA_WIDTH(+parity), DEPTH words, we, read enable, registered output. Instantiated BANKS times via generate.

Test Plan:
- Load bank0 row r with lane j = r*16+j and bank1 likewise +1000, r=0..63. Then start base=0, len=4 -> q_valid high cycles 2..5 after start. Bank0 rows 0..3, bank1 rows 1..4; done pulses the cycle after the last q_valid.
- start base=62, len=3 -> bank0 rows 62,63,0; bank1 rows 63,0,1.
- hold asserted 3 cycles mid-run -> q frozen and q_valid unchanged during hold. Total valid rows still equal len, in order with no duplicates.
- start with len=0 -> no q_valid; done pulses one cycle later; busy stays 0.
- wr_valid during RUN with new data -> wr_ready=0 and memory unchanged (verified by a later read). start while busy is ignored.
- reset asserted mid-RUN -> next cycle q_valid=0, busy=0, no done. A subsequent run reads previously loaded data intact. With WEIGHT_BUFFER_PARITY_EN, a bank bit forced flipped -> parity_err=1 aligned with that row.

Source files
------------

// File: rtl/weight_buffer_banked_pkg.sv
// Shared types and helpers for the banked LSTM weight buffer.
// Optional per-lane parity storage is enabled by defining WEIGHT_BUFFER_PARITY_EN.
package weight_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

`ifdef WEIGHT_BUFFER_PARITY_EN
    localparam int unsigned PARITY_BITS = 32'd1;
`else
    localparam int unsigned PARITY_BITS = 32'd0;
`endif

    function automatic int unsigned ram_word_width(input int unsigned lanes, input int unsigned data_width);
        return lanes * (data_width + PARITY_BITS);
    endfunction

    // Explicit modulo keeps wrap correct for non-power-of-two depths.
    function automatic int unsigned bank_addr(input int unsigned base, input int unsigned idx,
                                              input int unsigned bank, input int unsigned stride,
                                              input int unsigned depth);
        return (base + idx + bank * stride) % depth;
    endfunction

    function automatic logic even_parity(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/weight_buffer_banked_ram.sv
// Single-port weight bank with registered read port; optional parity per lane
// (WEIGHT_BUFFER_PARITY_EN) stored above the data bits.
module weight_bank_ram
    import weight_buffer_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    localparam int DATA_W    = LANES * DATA_WIDTH,
    localparam int RAM_W     = int'(ram_word_width(LANES, DATA_WIDTH))
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     din,
`ifdef WEIGHT_BUFFER_PARITY_EN
    output logic                  rd_par_err,
`endif
    output logic [DATA_W-1:0]     dout
);

    logic [RAM_W-1:0]  mem_r [DEPTH];
    logic [RAM_W-1:0]  wr_word_s;
    logic [RAM_W-1:0]  rd_word_s;
    logic [DATA_W-1:0] dout_r;

    assign rd_word_s = mem_r[addr];
    assign dout      = dout_r;

`ifdef WEIGHT_BUFFER_PARITY_EN
    logic [LANES-1:0] wr_par_s;
    logic [LANES-1:0] rd_par_s;

    // Per-lane parity for the incoming word and for the word being read.
    always_comb begin
        wr_par_s = '0;
        rd_par_s = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_par_s[l] = even_parity(64'(din[l*DATA_WIDTH +: DATA_WIDTH]));
            rd_par_s[l] = even_parity(64'(rd_word_s[l*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    assign wr_word_s  = {wr_par_s, din};
    assign rd_par_err = |(rd_par_s ^ rd_word_s[RAM_W-1 -: LANES]);
`else
    assign wr_word_s = din;
`endif

    // Storage array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wr_word_s;
        end
    end

    // Read register only advances when enabled so the output holds under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r <= '0;
        end else if (re) begin
            dout_r <= rd_word_s[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/weight_buffer_banked.sv
// Banked weight buffer: host write port plus lock-step streaming sequencer.
// Defining WEIGHT_BUFFER_PARITY_EN adds per-lane parity and the parity_err output.
module weight_buffer_banked
    import weight_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 18,
    parameter int LANES       = 16,
    parameter int BANKS       = 2,
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int BANK_STRIDE = 1,
    localparam int BANK_W     = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int WORD_W     = LANES * DATA_WIDTH
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [BANK_W-1:0]       wr_bank,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WORD_W-1:0]       wr_data,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_index,
    input  logic [ADDR_WIDTH:0]     len,
    input  logic                    hold,
    output logic                    busy,
    output logic                    done,
`ifdef WEIGHT_BUFFER_PARITY_EN
    output logic                    parity_err,
`endif
    output logic [BANKS*WORD_W-1:0] q,
    output logic                    q_valid
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   idx_r;
    logic                  s1_valid_r;
    logic                  q_valid_r;
    logic                  done_r;
    logic                  busy_r;
    logic                  wr_ready_r;
    logic [ADDR_WIDTH-1:0] s1_addr_r    [BANKS];
    logic [ADDR_WIDTH-1:0] issue_addr_s [BANKS];
    logic                  wr_fire_s;
    logic                  rd_en_s;

    assign wr_fire_s = wr_valid && wr_ready_r;
    assign rd_en_s   = s1_valid_r && !hold;
    assign wr_ready  = wr_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign q_valid   = q_valid_r;

    // Row address each bank would read for the current issue index.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            issue_addr_s[b] = ADDR_WIDTH'(bank_addr(32'(base_r), 32'(idx_r), 32'(b),
                                                    32'(BANK_STRIDE), 32'(DEPTH)));
        end
    end

`ifdef WEIGHT_BUFFER_PARITY_EN
    logic [BANKS-1:0] bank_err_s;
    logic             parity_err_r;
    assign parity_err = parity_err_r;

    // Parity flag shares the stage-2 enable so it lines up with q_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_r <= 1'b0;
        end else if (!hold) begin
            parity_err_r <= s1_valid_r && (|bank_err_s);
        end
    end
`endif

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic                  we_s;
        logic [ADDR_WIDTH-1:0] addr_s;

        // Writes only happen in IDLE, reads only while the pipeline holds a row.
        assign we_s   = wr_fire_s && (32'(wr_bank) == 32'(b));
        assign addr_s = we_s ? wr_addr : s1_addr_r[b];

        weight_bank_ram #(
            .LANES      (LANES),
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk        (clk),
            .reset      (reset),
            .we         (we_s),
            .re         (rd_en_s),
            .addr       (addr_s),
            .din        (wr_data),
`ifdef WEIGHT_BUFFER_PARITY_EN
            .rd_par_err (bank_err_s[b]),
`endif
            .dout       (q[b*WORD_W +: WORD_W])
        );
    end

    // Sequencer FSM and stage-1/valid pipeline; hold freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            base_r     <= '0;
            len_r      <= '0;
            idx_r      <= '0;
            s1_valid_r <= 1'b0;
            q_valid_r  <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b0;
            for (int b = 0; b < BANKS; b++) begin
                s1_addr_r[b] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            if (!hold) begin
                s1_valid_r <= 1'b0;
                q_valid_r  <= s1_valid_r;
                case (state_r)
                    IDLE: begin
                        wr_ready_r <= 1'b1;
                        if (start) begin
                            base_r <= base_index;
                            len_r  <= len;
                            idx_r  <= '0;
                            if (len != '0) begin
                                state_r    <= RUN;
                                busy_r     <= 1'b1;
                                wr_ready_r <= 1'b0;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        s1_valid_r <= 1'b1;
                        for (int b = 0; b < BANKS; b++) begin
                            s1_addr_r[b] <= issue_addr_s[b];
                        end
                        if (idx_r == len_r - CNT_ONE) begin
                            state_r <= DRAIN;
                        end else begin
                            idx_r <= idx_r + CNT_ONE;
                        end
                    end
                    DRAIN: begin
                        // Last row is on q now; it retires at this edge.
                        if (!s1_valid_r && q_valid_r) begin
                            state_r    <= IDLE;
                            busy_r     <= 1'b0;
                            wr_ready_r <= 1'b1;
                            done_r     <= 1'b1;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        wr_ready_r <= 1'b0;
                    end
                endcase
            end else if (state_r == IDLE) begin
                wr_ready_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_buffer_banked.sv
// Directed self-checking bench for weight_buffer_banked (default 2x16x18, depth 64).
module tb_weight_buffer_banked;

    localparam int DW    = 18;
    localparam int LANES = 16;
    localparam int BANKS = 2;
    localparam int WW    = LANES * DW;
    localparam int QW    = BANKS * WW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [0:0]    wr_bank;
    logic [5:0]    wr_addr;
    logic [WW-1:0] wr_data;
    logic          start;
    logic [5:0]    base_index;
    logic [6:0]    len;
    logic          hold;
    logic          busy;
    logic          done;
    logic [QW-1:0] q;
    logic          q_valid;
`ifdef WEIGHT_BUFFER_PARITY_EN
    logic          parity_err;
`endif

    int errors = 0;
    int checks = 0;

    weight_buffer_banked dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .base_index (base_index),
        .len        (len),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
`ifdef WEIGHT_BUFFER_PARITY_EN
        .parity_err (parity_err),
`endif
        .q          (q),
        .q_valid    (q_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] bank_word(input int b, input int r);
        logic [WW-1:0] w;
        w = '0;
        for (int j = 0; j < LANES; j++) begin
            w[j*DW +: DW] = DW'(r * 16 + j + ((b == 1) ? 1000 : 0));
        end
        return w;
    endfunction

    function automatic logic [QW-1:0] exp_row(input int base, input int k);
        logic [QW-1:0] v;
        v = '0;
        for (int b = 0; b < BANKS; b++) begin
            v[b*WW +: WW] = bank_word(b, (base + k + b) % 64);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base_index = '0; len = '0; hold = 1'b0;
        tick();
        tick();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
        checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
        reset = 1'b0;
        tick();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready got=%b exp=1", wr_ready); end
    endtask

    task automatic load_all();
        for (int r = 0; r < 64; r++) begin
            for (int b = 0; b < BANKS; b++) begin
                wr_valid = 1'b1;
                wr_bank  = 1'(b);
                wr_addr  = 6'(r);
                wr_data  = bank_word(b, r);
                tick();
            end
        end
        wr_valid = 1'b0;
    endtask

    // Runs one stream; with inject set, pokes a write and a second start while busy.
    task automatic test_stream(input int base, input int n, input bit inject);
        base_index = 6'(base);
        len        = 7'(n);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= n + 2; t++) begin
            tick();
            wr_valid = 1'b0;
            start    = 1'b0;
            checks++;
            if (q_valid !== ((t >= 2) && (t <= n + 1))) begin
                errors++; $display("FAIL stream_q_valid base=%0d t=%0d got=%b", base, t, q_valid);
            end
            if ((t >= 2) && (t <= n + 1)) begin
                checks++;
                if (q !== exp_row(base, t - 2)) begin
                    errors++; $display("FAIL stream_q base=%0d k=%0d got=%h exp=%h", base, t - 2, q, exp_row(base, t - 2));
                end
`ifdef WEIGHT_BUFFER_PARITY_EN
                checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL stream_parity got=%b exp=0", parity_err); end
`endif
            end
            checks++;
            if (done !== (t == n + 2)) begin
                errors++; $display("FAIL stream_done base=%0d t=%0d got=%b", base, t, done);
            end
            if (t == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy got=%b exp=1", busy); end
                checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL stream_wr_ready got=%b exp=0", wr_ready); end
                if (inject) begin
                    wr_valid   = 1'b1;
                    wr_bank    = 1'b0;
                    wr_addr    = 6'(base + 1);
                    wr_data    = '1;
                    start      = 1'b1;
                    base_index = 6'd40;
                end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_end_busy got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream_done_width got=%b exp=0", done); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL stream_tail_valid got=%b exp=0", q_valid); end
    endtask

    task automatic test_basic();
        test_stream(0, 4, 1'b0);
        test_stream(62, 3, 1'b0);
    endtask

    task automatic test_hold();
        logic [QW-1:0] prev_q;
        logic          prev_qv;
        bit            hold_now;
        int            k;
        int            done_cnt;
        k = 0; done_cnt = 0;
        base_index = 6'd10; len = 7'd6; start = 1'b1;
        tick();
        start = 1'b0;
        prev_q = q; prev_qv = q_valid;
        for (int t = 1; t <= 20; t++) begin
            hold_now = (t >= 3) && (t <= 5);
            hold = hold_now;
            tick();
            hold = 1'b0;
            if (done) done_cnt++;
            if (hold_now) begin
                checks++;
                if ((q !== prev_q) || (q_valid !== prev_qv)) begin
                    errors++; $display("FAIL hold_frozen t=%0d q_valid got=%b exp=%b", t, q_valid, prev_qv);
                end
            end else if (q_valid) begin
                checks++;
                if (q !== exp_row(10, k)) begin
                    errors++; $display("FAIL hold_row k=%0d got=%h exp=%h", k, q, exp_row(10, k));
                end
                k++;
            end
            prev_q = q; prev_qv = q_valid;
        end
        checks++; if (k != 6) begin errors++; $display("FAIL hold_row_count got=%0d exp=6", k); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL hold_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_len_zero();
        base_index = 6'd7; len = 7'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got=%b exp=0", busy); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL len0_q_valid got=%b exp=0", q_valid); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_pulse got=%b exp=0", done); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL len0_no_valid got=%b exp=0", q_valid); end
    endtask

    task automatic test_write_while_busy();
        test_stream(20, 4, 1'b1);
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if ((busy !== 1'b0) || (q_valid !== 1'b0)) begin
                errors++; $display("FAIL ignored_start busy=%b q_valid=%b exp=0", busy, q_valid);
            end
        end
        test_stream(21, 1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        base_index = 6'd5; len = 7'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL midrun_valid got=%b exp=1", q_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL abort_q_valid got=%b exp=0", q_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++;
            if ((done !== 1'b0) || (q_valid !== 1'b0)) begin
                errors++; $display("FAIL abort_quiet t=%0d done=%b q_valid=%b", t, done, q_valid);
            end
        end
        test_stream(5, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        load_all();
        test_basic();
        test_hold();
        test_len_zero();
        test_write_while_busy();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
